// File: rtl/muldiv_unit.sv
// muldiv_unit
//   Iterative signed/unsigned multiply/divide unit feeding the HI/LO write
//   path of the multicycle CPU. One accepted operation runs WIDTH shift
//   iterations followed by a single sign-fix cycle, then pulses done.
//
// Ports
//   clk       rising-edge clock
//   reset     asynchronous, active-low reset
//   start     request, sampled only while idle
//   op        00=MULT 01=MULTU 10=DIV 11=DIVU
//   a, b      multiplicand/dividend, multiplier/divisor
//   busy      high from the accept edge to the done edge
//   done      one-cycle pulse, hi/lo/div_zero valid from this cycle
//   div_zero  divide with b==0, held until the next accept
//   hi, lo    MULT: product high/low halves; DIV: remainder/quotient
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t           state;
    logic             is_div;
    logic             is_signed;
    logic             sign_q;
    logic             sign_r;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] work_hi;
    logic [WIDTH-1:0] work_lo;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [WIDTH-1:0]   addend;
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ge;
    logic [2*WIDTH-1:0] product;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   rem;

    // Operand magnitudes at accept, one shift-add / restoring-divide step
    // on the working registers, and the sign-corrected final results.
    // work_hi:work_lo is the 2W-bit product accumulator for MULT, and the
    // partial remainder : dividend/quotient shift register for DIV.
    // The partial remainder is always below the divisor, so bit W of the
    // trial difference is a clean borrow flag.
    always_comb begin
        in_a = (!op[0] && a[WIDTH-1]) ? -a : a;
        in_b = (!op[0] && b[WIDTH-1]) ? -b : b;

        addend  = work_lo[0] ? mag_a : '0;
        mul_sum = {1'b0, work_hi} + {1'b0, addend};

        div_shift = {work_hi, work_lo[WIDTH-1]};
        div_diff  = div_shift - {1'b0, mag_b};
        div_ge    = ~div_diff[WIDTH];

        product = {work_hi, work_lo};
        quot    = work_lo;
        rem     = work_hi;
        if (is_signed && sign_q) begin
            product = -product;
            quot    = -quot;
        end
        if (is_signed && sign_r) begin
            rem = -rem;
        end
    end

    // Control FSM and datapath registers. hi/lo only change on the fix
    // edge; a divide by zero skips the iterations and leaves them alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            div_zero  <= 1'b0;
            hi        <= '0;
            lo        <= '0;
            count     <= '0;
            is_div    <= 1'b0;
            is_signed <= 1'b0;
            sign_q    <= 1'b0;
            sign_r    <= 1'b0;
            mag_a     <= '0;
            mag_b     <= '0;
            work_hi   <= '0;
            work_lo   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        is_div    <= op[1];
                        is_signed <= ~op[0];
                        sign_q    <= a[WIDTH-1] ^ b[WIDTH-1];
                        sign_r    <= a[WIDTH-1];
                        mag_a     <= in_a;
                        mag_b     <= in_b;
                        work_hi   <= '0;
                        work_lo   <= op[1] ? in_a : in_b;
                        count     <= '0;
                        busy      <= 1'b1;
                        div_zero  <= 1'b0;
                        state     <= (op[1] && b == '0) ? FIX : RUN;
                    end
                end
                RUN: begin
                    if (is_div) begin
                        work_hi <= div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
                        work_lo <= {work_lo[WIDTH-2:0], div_ge};
                    end else begin
                        work_hi <= mul_sum[WIDTH:1];
                        work_lo <= {mul_sum[0], work_lo[WIDTH-1:1]};
                    end
                    count <= count + CW'(1);
                    if (count == CW'(WIDTH - 1)) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    if (is_div && mag_b == '0) begin
                        div_zero <= 1'b1;
                    end else if (is_div) begin
                        hi <= rem;
                        lo <= quot;
                    end else begin
                        hi <= product[2*WIDTH-1:WIDTH];
                        lo <= product[WIDTH-1:0];
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
